// File: rtl/milano_pkg.sv
// Shared types and constants for the milano EX-stage multiply/divide unit.
package milano_pkg;

  localparam int unsigned MDU_XLEN = 32;
  localparam int unsigned MDU_ITER = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_BUSY,
    MDU_FAST,
    MDU_DONE
  } mdu_state_e;

  // rs1 is interpreted as signed for these ops
  function automatic logic op_a_signed(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is interpreted as signed for these ops
  function automatic logic op_b_signed(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring-divide step.
// Multiply: acc = {partial_hi, multiplier_lo}, opb = multiplicand.
// Divide:   acc = {remainder, dividend/quotient}, opb = divisor.
module mdu_iter_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] rem_diff;

  // Select between add-and-shift-right and shift-left-and-trial-subtract
  always_comb begin
    mul_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : {(XLEN+1){1'b0}});
    rem_sh   = acc_i[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, opb_i};
    if (is_div_i) begin
      if (rem_diff[XLEN]) begin
        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {rem_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit in the EX stage; stalls upstream while busy.
module ex_mdu
  import milano_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN,
  parameter int unsigned ITER = MDU_ITER
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o
);

  localparam int unsigned CNT_W = $clog2(ITER);
  localparam int unsigned ACC_W = 2 * XLEN;

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic              neg_q, neg_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              rd_we_lat_q, rd_we_lat_d;
  logic              rd_we_q, rd_we_d;

  mdu_op_e           op_in;
  logic              accept;
  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_res;
  logic [ACC_W-1:0]  step_acc;
  logic [ACC_W-1:0]  prod_fix;
  logic [XLEN-1:0]   div_val;
  logic [XLEN-1:0]   fin_res;

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (step_acc)
  );

  // Operand sign stripping and special-case detection at accept
  always_comb begin
    op_in    = mdu_op_e'(op_i);
    accept   = (state_q == MDU_IDLE) && start_i && !flush_i && !rst_i;
    sgn_a    = op_a_signed(op_in) && rs1_data_i[XLEN-1];
    sgn_b    = op_b_signed(op_in) && rs2_data_i[XLEN-1];
    mag_a    = sgn_a ? XLEN'(0) - rs1_data_i : rs1_data_i;
    mag_b    = sgn_b ? XLEN'(0) - rs2_data_i : rs2_data_i;
    div_zero = op_i[2] && (rs2_data_i == '0);
    div_ovf  = op_i[2] && !op_i[0] && (rs1_data_i == XLEN'(DIV_OVF_Q)) && (rs2_data_i == '1);
    if (div_zero) begin
      fast_res = op_i[1] ? rs1_data_i : XLEN'(DIV_BY_ZERO_Q);
    end else begin
      fast_res = op_i[1] ? '0 : XLEN'(DIV_OVF_Q);
    end
  end

  // Sign fix-up of the final iteration result
  always_comb begin
    prod_fix = neg_q ? ACC_W'(0) - step_acc : step_acc;
    div_val  = op_q[1] ? step_acc[ACC_W-1:XLEN] : step_acc[XLEN-1:0];
    if (op_q[2]) begin
      fin_res = neg_q ? XLEN'(0) - div_val : div_val;
    end else if (op_q == MDU_MUL) begin
      fin_res = prod_fix[XLEN-1:0];
    end else begin
      fin_res = prod_fix[ACC_W-1:XLEN];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    valid_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_we_lat_d = rd_we_lat_q;
    rd_we_d     = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          op_d        = op_in;
          rd_addr_d   = rd_addr_i;
          rd_we_lat_d = rd_we_i;
          neg_d       = (op_i[2] && op_i[1]) ? sgn_a : (sgn_a ^ sgn_b);
          cnt_d       = CNT_W'(ITER - 1);
          if (div_zero || div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, fast_res};
            opb_d   = '0;
            state_d = MDU_FAST;
          end else if (op_i[2]) begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            opb_d   = mag_b;
            state_d = MDU_BUSY;
          end else begin
            acc_d   = {{XLEN{1'b0}}, mag_b};
            opb_d   = mag_a;
            state_d = MDU_BUSY;
          end
        end
      end
      MDU_BUSY: begin
        if (flush_i) begin
          state_d = MDU_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d  = MDU_DONE;
            result_d = fin_res;
            valid_d  = 1'b1;
            rd_we_d  = rd_we_lat_q;
          end
        end
      end
      MDU_FAST: begin
        if (flush_i) begin
          state_d = MDU_IDLE;
        end else begin
          state_d  = MDU_DONE;
          result_d = acc_q[XLEN-1:0];
          valid_d  = 1'b1;
          rd_we_d  = rd_we_lat_q;
        end
      end
      MDU_DONE: begin
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= MDU_IDLE;
      op_q        <= MDU_MUL;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_we_lat_q <= 1'b0;
      rd_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_lat_q <= rd_we_lat_d;
      rd_we_q     <= rd_we_d;
    end
  end

  assign stall_o        = accept || (state_q == MDU_BUSY) || (state_q == MDU_FAST);
  assign busy_o         = (state_q != MDU_IDLE);
  assign result_valid_o = valid_q;
  assign result_o       = result_q;
  assign rd_addr_o      = rd_addr_q;
  assign rd_we_o        = rd_we_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed cases plus random ops vs. an arithmetic model.
module tb_ex_mdu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  ex_mdu dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .op_i           (op_i),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .rd_addr_i      (rd_addr_i),
    .rd_we_i        (rd_we_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .rd_addr_o      (rd_addr_o),
    .rd_we_o        (rd_we_o)
  );

  always #5 clk_i = ~clk_i;

  // RV32M semantics computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int          sa;
    int          sb;
    longint      p;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op starting at posedge+1 of an IDLE cycle; returns at posedge+1 after DONE.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic we, input logic [31:0] exp_res,
                       input string tag);
    int   exp_lat;
    int   lat;
    logic stall_bad;
    exp_lat = (op[2] && (b == 32'd0 ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 33;
    chk({tag, " idle_before"}, 32'(busy_o), 32'd0);
    start_i    = 1'b1;
    op_i       = op;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = rd;
    rd_we_i    = we;
    @(negedge clk_i);
    stall_bad = !stall_o;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    op_i       = 3'($urandom);
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    rd_addr_i  = 5'($urandom);
    rd_we_i    = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (result_valid_o) begin
        lat = c;
        break;
      end
      if (!stall_o) stall_bad = 1'b1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result_o, exp_res);
    chk({tag, " rd_addr"}, 32'(rd_addr_o), 32'(rd));
    chk({tag, " rd_we"}, 32'(rd_we_o), 32'(we));
    chk({tag, " stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, " stall_busy"}, 32'(stall_bad), 32'd0);
    @(posedge clk_i); #1;
    chk({tag, " valid_drop"}, 32'(result_valid_o), 32'd0);
    chk({tag, " rd_we_drop"}, 32'(rd_we_o), 32'd0);
    chk({tag, " result_held"}, result_o, exp_res);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        seen;

    rst_i      = 1'b1;
    start_i    = 1'b0;
    op_i       = 3'd0;
    rs1_data_i = 32'd0;
    rs2_data_i = 32'd0;
    rd_addr_i  = 5'd0;
    rd_we_i    = 1'b0;
    flush_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset valid", 32'(result_valid_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset rd_addr", 32'(rd_addr_o), 32'd0);
    chk("reset rd_we", 32'(rd_we_o), 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed: multiply family
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB, "mul");
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b1, 32'h4000_0000, "mulh");
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0, 32'hFFFF_FFFE, "mulhu");
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'hFFFF_FFFF, "mulhsu");

    // Directed: divides, issued back to back
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1, 32'hFFFF_FFFD, "div");
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1, 32'hFFFF_FFFF, "rem");
    issue(3'd5, 32'd100, 32'd7, 5'd11, 1'b1, 32'd14, "divu");
    issue(3'd7, 32'd100, 32'd7, 5'd12, 1'b1, 32'd2, "remu");

    // Directed: fast-path special cases
    issue(3'd5, 32'd5, 32'd0, 5'd13, 1'b1, 32'hFFFF_FFFF, "divu_by0");
    issue(3'd6, 32'd5, 32'd0, 5'd14, 1'b1, 32'd5, "rem_by0");
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h8000_0000, "div_ovf");
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'd0, "rem_ovf");

    // Flush in BUSY cycle 10, then a new op the very next cycle
    start_i    = 1'b1;
    op_i       = 3'd5;
    rs1_data_i = 32'd1000;
    rs2_data_i = 32'd7;
    rd_addr_i  = 5'd20;
    rd_we_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush busy", 32'(busy_o), 32'd0);
    chk("flush valid", 32'(result_valid_o), 32'd0);
    chk("flush stall", 32'(stall_o), 32'd0);
    issue(3'd5, 32'd9, 32'd3, 5'd21, 1'b1, 32'd3, "after_flush");

    // Reset in the middle of BUSY with start_i held high
    start_i    = 1'b1;
    op_i       = 3'd0;
    rs1_data_i = 32'd3;
    rs2_data_i = 32'd4;
    rd_addr_i  = 5'd22;
    rd_we_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i   = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    chk("midrst busy", 32'(busy_o), 32'd0);
    chk("midrst valid", 32'(result_valid_o), 32'd0);
    chk("midrst result", result_o, 32'd0);
    chk("midrst rd_addr", 32'(rd_addr_o), 32'd0);
    chk("midrst rd_we", 32'(rd_we_o), 32'd0);
    chk("midrst stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i   = 1'b0;
    start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (busy_o || result_valid_o) seen = 1'b1;
    end
    chk("midrst no_activity", 32'(seen), 32'd0);
    @(posedge clk_i); #1;

    // Random ops against the model, biased toward corner operands
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      issue(rop, ra, rb, 5'($urandom), 1'($urandom), ref_model(rop, ra, rb), "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
